// File: rtl/tracking_loop_arbiter.sv
// Round-robin arbiter sharing one tracking-loop datapath among NUM_CHANNELS channels.
// Latches per-channel requests, issues one grant at a time and returns results to the owner.
module tracking_loop_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int HIST_WIDTH   = 256,
    parameter int RESULT_WIDTH = 128,
    parameter int LOOP_TIMEOUT = 1023
) (
    input  logic                               clk,
    input  logic                               global_reset_n,
    input  logic [NUM_CHANNELS-1:0]            channel_enable,
    input  logic [NUM_CHANNELS-1:0]            i2q2_valid,
    input  logic [NUM_CHANNELS*HIST_WIDTH-1:0] hist_in,
    output logic                               loop_start,
    output logic [HIST_WIDTH-1:0]              loop_hist,
    input  logic                               loop_ready,
    input  logic [RESULT_WIDTH-1:0]            loop_result,
    output logic [NUM_CHANNELS-1:0]            tracking_ready,
    output logic [RESULT_WIDTH-1:0]            result_out,
    output logic [$clog2(NUM_CHANNELS)-1:0]    result_channel,
    output logic                               busy,
    output logic [NUM_CHANNELS-1:0]            overrun,
    output logic                               timeout,
    output logic [1:0]                         state_dbg
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int TW = $clog2(LOOP_TIMEOUT + 1);

    // Handshake: i2q2_valid, loop_start, loop_ready and tracking_ready are all single-cycle
    // strobes with no back-pressure; data travels alongside its strobe in the same cycle.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_CHANNELS-1:0]   pending_q, pending_d;
    logic [CW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]             gnt_q, gnt_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      loop_start_q, loop_start_d;
    logic [HIST_WIDTH-1:0]     loop_hist_q, loop_hist_d;
    logic [NUM_CHANNELS-1:0]   tracking_ready_q, tracking_ready_d;
    logic [RESULT_WIDTH-1:0]   result_q, result_d;
    logic [CW-1:0]             result_channel_q, result_channel_d;
    logic                      busy_q, busy_d;
    logic [NUM_CHANNELS-1:0]   overrun_q, overrun_d;
    logic                      timeout_q, timeout_d;

    logic                      pick_found;
    logic [CW-1:0]             pick_idx;
    logic [NUM_CHANNELS-1:0]   pick_oh;
    logic [NUM_CHANNELS-1:0]   gnt_oh;
    logic [NUM_CHANNELS-1:0]   req_set;
    logic [NUM_CHANNELS-1:0]   grant_clr;
    logic [CW-1:0]             gnt_next;

    assign req_set  = i2q2_valid & channel_enable;
    assign pick_oh  = {{(NUM_CHANNELS-1){1'b0}}, 1'b1} << pick_idx;
    assign gnt_oh   = {{(NUM_CHANNELS-1){1'b0}}, 1'b1} << gnt_q;
    assign gnt_next = (gnt_q == CW'(NUM_CHANNELS - 1)) ? '0 : gnt_q + 1'b1;

    // First pending channel at or above rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!pick_found && pending_q[(int'(rr_ptr_q) + i) % NUM_CHANNELS]) begin
                pick_found = 1'b1;
                pick_idx   = CW'((int'(rr_ptr_q) + i) % NUM_CHANNELS);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        gnt_d            = gnt_q;
        timer_d          = timer_q;
        loop_start_d     = 1'b0;
        loop_hist_d      = loop_hist_q;
        tracking_ready_d = '0;
        result_d         = result_q;
        result_channel_d = result_channel_q;
        timeout_d        = timeout_q;
        grant_clr        = '0;
        overrun_d        = overrun_q | (req_set & pending_q);

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d        = pick_idx;
                    loop_hist_d  = hist_in[int'(pick_idx)*HIST_WIDTH +: HIST_WIDTH];
                    grant_clr    = pick_oh;
                    loop_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready arriving on the final timer count still completes normally.
                if (loop_ready) begin
                    result_d         = loop_result;
                    result_channel_d = gnt_q;
                    tracking_ready_d = gnt_oh;
                    state_d          = S_DONE;
                end else if (timer_q == TW'(LOOP_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = gnt_next;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                rr_ptr_d = gnt_next;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new request on the same edge as a clear keeps the channel pending.
        pending_d = (pending_q & ~(grant_clr | ~channel_enable)) | req_set;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q          <= S_IDLE;
            pending_q        <= '0;
            rr_ptr_q         <= '0;
            gnt_q            <= '0;
            timer_q          <= '0;
            loop_start_q     <= 1'b0;
            loop_hist_q      <= '0;
            tracking_ready_q <= '0;
            result_q         <= '0;
            result_channel_q <= '0;
            busy_q           <= 1'b0;
            overrun_q        <= '0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            rr_ptr_q         <= rr_ptr_d;
            gnt_q            <= gnt_d;
            timer_q          <= timer_d;
            loop_start_q     <= loop_start_d;
            loop_hist_q      <= loop_hist_d;
            tracking_ready_q <= tracking_ready_d;
            result_q         <= result_d;
            result_channel_q <= result_channel_d;
            busy_q           <= busy_d;
            overrun_q        <= overrun_d;
            timeout_q        <= timeout_d;
        end
    end

    assign loop_start     = loop_start_q;
    assign loop_hist      = loop_hist_q;
    assign tracking_ready = tracking_ready_q;
    assign result_out     = result_q;
    assign result_channel = result_channel_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;
    assign state_dbg      = state_q;

endmodule

// File: doc/tracking_loop_arbiter.md
Name: tracking_loop_arbiter

Overview:
- Shares one tracking_loops instance between NUM_CHANNELS channel instances.
- Each channel pulses i2q2_valid at the end of an accumulation. The arbiter latches the request, grants channels round-robin, and forwards the granted channel's history bundle to the loops with a one-cycle start strobe.
- It waits for the loops' ready strobe, then returns the result bundle and a per-channel tracking_ready pulse to the owning channel.
- Sits between the channel array and the single loop filter datapath in the top level.

Parameters:
- NUM_CHANNELS, 4, number of requesting channels (2..16).
- HIST_WIDTH, 256, width of one packed channel history bundle (i2q2 E/P/L, iq/i/q prompt k and k-1, w_df, w_df_dot).
- RESULT_WIDTH, 128, width of one packed tracking result bundle (iq_prompt_k, doppler_inc_kp1, w_df_kp1, w_df_dot_kp1, ca_dphi_kp1).
- LOOP_TIMEOUT, 1023, maximum cycles to wait for loop_ready before abandoning a grant.

Ports:
- clk  in  1  system clock.
- global_reset_n  in  1  asynchronous, active-low reset.
- channel_enable  in  NUM_CHANNELS  per-channel enable; a disabled channel's requests are ignored.
- i2q2_valid  in  NUM_CHANNELS  per-channel one-cycle request pulse.
- hist_in  in  NUM_CHANNELS*HIST_WIDTH  flattened history; channel c occupies bits [c*HIST_WIDTH +: HIST_WIDTH].
- loop_start  out  1  one-cycle strobe to the loops (drives i2q2_valid_0).
- loop_hist  out  HIST_WIDTH  registered history of the granted channel.
- loop_ready  in  1  loops done strobe (tracking_ready_0).
- loop_result  in  RESULT_WIDTH  loop outputs, valid with loop_ready.
- tracking_ready  out  NUM_CHANNELS  one-hot one-cycle completion pulse to the owning channel.
- result_out  out  RESULT_WIDTH  registered result, valid while tracking_ready is nonzero and held until the next completion.
- result_channel  out  $clog2(NUM_CHANNELS)  channel index of result_out.
- busy  out  1  high in every state except IDLE.
- overrun  out  NUM_CHANNELS  sticky: a request arrived while that channel was already pending.
- timeout  out  1  sticky: a grant was abandoned because loop_ready never arrived.

Behaviour:
- Reset (asynchronous, global_reset_n low) clears every register:
  - state=IDLE; all pending bits 0; rr_ptr=0.
  - loop_start=0, loop_hist=0, tracking_ready=0, result_out=0, result_channel=0.
  - busy=0, overrun=0, timeout=0, timer=0.
  - Reset asserted mid-grant abandons the grant silently; no tracking_ready is issued.
- Pending bits:
  - pending[c] is set on the edge where i2q2_valid[c] && channel_enable[c].
  - It is cleared when channel c is granted, and cleared whenever channel_enable[c]=0.
  - A set and a clear in the same cycle: set wins.
  - If pending[c] is already 1 when a new request for c arrives, overrun[c] is set (sticky until reset) and the request merges into the existing pending bit.
- State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  - IDLE: if any pending bit is set, select the first set bit searching from rr_ptr upward with wrap-around.
    - Register the selected index as gnt, copy that channel's hist_in slice into loop_hist, clear its pending bit, and go to ISSUE.
  - ISSUE: loop_start=1 for exactly this one cycle; timer cleared; go to WAIT.
  - WAIT: timer increments each cycle.
    - If loop_ready=1, register loop_result into result_out, set result_channel=gnt, and go to DONE.
    - Otherwise, if timer==LOOP_TIMEOUT, set timeout, leave result_out unchanged, issue no tracking_ready, set rr_ptr=gnt+1 (mod NUM_CHANNELS), and go to IDLE.
    - loop_ready is honoured in the cycle timer reaches LOOP_TIMEOUT; ready takes priority over timeout.
  - DONE: tracking_ready[gnt]=1 for one cycle; rr_ptr=gnt+1 (mod NUM_CHANNELS); go to IDLE.
  - loop_ready outside WAIT is ignored.
- Timing:
  - Latency from an i2q2_valid pulse with the arbiter idle to loop_start is 2 cycles.
  - Latency from loop_ready to tracking_ready is 1 cycle.
  - A full grant occupies 4 + (loop latency) cycles.
- Requests arriving in any state are latched and never lost, including a new request from the channel currently being serviced; that one is served in its next round-robin turn.
- loop_hist is stable from ISSUE until the next grant. The channel may update hist_in freely after the grant edge.
- Clearing channel_enable[gnt] during WAIT does not abort the grant; its result is still delivered.

Test Plan:
- Single request, channel 2 only (enable=4'b1111): i2q2_valid[2] at cycle 0 -> loop_start high at cycle 2 with loop_hist = ch2 slice. Then loop_ready with result 0xABC at cycle 10 -> tracking_ready=4'b0100 at cycle 11, result_out=0xABC, result_channel=2.
- Simultaneous requests on ch0, ch1, ch3, loops answering 5 cycles after each start -> grants in order 0, 1, 3; each tracking_ready pulse lands only on the owner; no overrun.
- Fairness: ch0 re-requests immediately after each completion while ch1 requests once -> after ch0 is served, ch1 is served before ch0 again.
- Overrun: ch1 pulses twice while ch0's grant is in WAIT -> overrun=4'b0010; ch1 is served exactly once.
- Timeout with LOOP_TIMEOUT=15: loop_ready is never asserted -> timeout=1 after 16 WAIT cycles; no tracking_ready; the next pending channel is granted. Repeat with loop_ready arriving on the cycle timer==15 -> normal completion, timeout stays 0.
- Reset mid-WAIT: assert global_reset_n=0 asynchronously -> all outputs 0 immediately; after release, a stale loop_ready produces no tracking_ready and busy=0.
